// File: rtl/tpu_issue_arbiter.sv
// Two-requester issue arbiter for the shared tpu instruction port.
// Round-robin between requesters, with a burst lock so a multi-word sequence
// issues without interleaving. A (valid, id) tag travels alongside each issued
// instruction so the tpu result can be routed back to its owner.
module tpu_issue_arbiter #(
  parameter int unsigned IW        = 16,
  parameter int unsigned RW        = 8,
  parameter int unsigned RES_LAT   = 2,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [IW-1:0] req0_instr_i,
  input  logic          req0_valid_i,
  input  logic          req0_last_i,
  output logic          req0_ready_o,
  input  logic [IW-1:0] req1_instr_i,
  input  logic          req1_valid_i,
  input  logic          req1_last_i,
  output logic          req1_ready_o,
  output logic [IW-1:0] tpu_instr_o,
  input  logic [RW-1:0] tpu_result_i,
  output logic [RW-1:0] rsp_data_o,
  output logic          rsp_valid_o,
  output logic          rsp_id_o,
  output logic          busy_o,
  output logic          owner_o
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                ptr_q, ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]       instr_q, instr_d;
  logic [RES_LAT-1:0]  tag_vld_q, tag_id_q;
  logic                rsp_valid_q, rsp_id_q;
  logic [RW-1:0]       rsp_data_q;

  logic                ready0, ready1;
  logic                xfer, xfer_id, xfer_last;
  logic [IW-1:0]       xfer_instr;

  // Grant: the lock owner while locked, otherwise the pointer-favoured valid requester.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (state_q == StLocked) begin
      ready0 = ~owner_q & req0_valid_i;
      ready1 = owner_q & req1_valid_i;
    end else if (ptr_q) begin
      ready1 = req1_valid_i;
      ready0 = req0_valid_i & ~req1_valid_i;
    end else begin
      ready0 = req0_valid_i;
      ready1 = req1_valid_i & ~req0_valid_i;
    end
  end

  // Ready already implies valid, so at most one of these is a transfer.
  assign xfer       = ready0 | ready1;
  assign xfer_id    = ready1;
  assign xfer_last  = ready1 ? req1_last_i : req0_last_i;
  assign xfer_instr = ready1 ? req1_instr_i : req0_instr_i;

  // Next-state for lock, pointer, burst count and the issued instruction.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    instr_d = xfer ? xfer_instr : '0;
    if (xfer) begin
      if (state_q == StIdle) begin
        owner_d = xfer_id;
        // A one-word burst limit makes every grant a single-word burst.
        if (xfer_last || MAX_BURST == 1) begin
          ptr_d = ~xfer_id;
        end else begin
          state_d = StLocked;
          cnt_d   = CntW'(1);
        end
      end else if (xfer_last || cnt_q == CntW'(MAX_BURST - 1)) begin
        state_d = StIdle;
        ptr_d   = ~owner_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Arbitration state and issue register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  // Tag pipeline: the last stage marks the cycle tpu_result belongs to an issued word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      tag_vld_q[0] <= xfer;
      tag_id_q[0]  <= xfer_id;
      for (int unsigned i = 1; i < RES_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      rsp_valid_q <= tag_vld_q[RES_LAT-1];
      if (tag_vld_q[RES_LAT-1]) begin
        rsp_data_q <= tpu_result_i;
        rsp_id_q   <= tag_id_q[RES_LAT-1];
      end
    end
  end

  assign req0_ready_o = ready0;
  assign req1_ready_o = ready1;
  assign tpu_instr_o  = instr_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign busy_o       = (state_q == StLocked) | (|tag_vld_q);
  assign owner_o      = owner_q;

endmodule

// File: tb/tb_tpu_issue_arbiter.sv
// Bench for tpu_issue_arbiter: directed requester scripts, a transaction-level
// model checked every cycle, and literal grant/issue/response sequences per scenario.
module tb_tpu_issue_arbiter;

  localparam int IW        = 16;
  localparam int RW        = 8;
  localparam int RES_LAT   = 2;
  localparam int MAX_BURST = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] req0_instr, req1_instr, tpu_instr;
  logic          req0_valid, req0_last, req0_ready;
  logic          req1_valid, req1_last, req1_ready;
  logic [RW-1:0] tpu_result, rsp_data;
  logic          rsp_valid, rsp_id, busy, owner;

  always #5 clk = ~clk;

  tpu_issue_arbiter #(
    .IW(IW), .RW(RW), .RES_LAT(RES_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_instr_i(req0_instr), .req0_valid_i(req0_valid), .req0_last_i(req0_last),
    .req0_ready_o(req0_ready),
    .req1_instr_i(req1_instr), .req1_valid_i(req1_valid), .req1_last_i(req1_last),
    .req1_ready_o(req1_ready),
    .tpu_instr_o(tpu_instr), .tpu_result_i(tpu_result),
    .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id),
    .busy_o(busy), .owner_o(owner)
  );

  function automatic logic [RW-1:0] hash(input logic [IW-1:0] x);
    return x[7:0] ^ x[15:8];
  endfunction

  // tpu stand-in (RES_LAT=2): result is valid the cycle after the instruction is shown.
  logic [IW-1:0] instr_d1;
  always @(posedge clk) instr_d1 <= tpu_instr;
  assign tpu_result = hash(instr_d1);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {int due; bit id; logic [IW-1:0] instr;} pend_t;
  pend_t         pend[$];
  int            cyc = 0;
  bit            m_valid = 1'b0;
  bit            m_locked, m_own, m_ptr, m_owner, m_rv, m_rid;
  int            m_cnt;
  logic [IW-1:0] m_instr;
  logic [RW-1:0] m_rdata;

  task automatic exp_ready(output bit r0, output bit r1);
    int win;
    r0 = 1'b0;
    r1 = 1'b0;
    win = -1;
    if (m_locked) begin
      if (!m_own && req0_valid) win = 0;
      if (m_own && req1_valid) win = 1;
    end else begin
      bit fav_v, oth_v;
      fav_v = m_ptr ? req1_valid : req0_valid;
      oth_v = m_ptr ? req0_valid : req1_valid;
      if (fav_v) win = m_ptr ? 1 : 0;
      else if (oth_v) win = m_ptr ? 0 : 1;
    end
    if (win == 0) r0 = 1'b1;
    if (win == 1) r1 = 1'b1;
  endtask

  always @(posedge clk) begin
    bit r0, r1, last;
    int g;
    logic [IW-1:0] ins;
    cyc++;
    if (rst) begin
      m_locked = 0; m_own = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
      m_instr = '0; m_rv = 0; m_rid = 0; m_rdata = '0;
      pend.delete();
      m_valid = 1'b1;
    end else if (m_valid) begin
      exp_ready(r0, r1);
      g = r0 ? 0 : (r1 ? 1 : -1);
      m_rv = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_rv    = 1'b1;
        m_rid   = pend[0].id;
        m_rdata = hash(pend[0].instr);
        void'(pend.pop_front());
      end
      m_instr = '0;
      if (g >= 0) begin
        last    = (g == 1) ? req1_last : req0_last;
        ins     = (g == 1) ? req1_instr : req0_instr;
        m_instr = ins;
        pend.push_back('{cyc + RES_LAT, (g == 1), ins});
        if (!m_locked) begin
          m_owner = (g == 1);
          if (last || MAX_BURST == 1) m_ptr = (g == 0);
          else begin m_locked = 1; m_own = (g == 1); m_cnt = 1; end
        end else begin
          m_cnt++;
          if (last || m_cnt == MAX_BURST) begin m_locked = 0; m_ptr = !m_own; end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit r0, r1;
    if (m_valid) begin
      exp_ready(r0, r1);
      check("req0_ready", req0_ready, r0);
      check("req1_ready", req1_ready, r1);
      check("tpu_instr", tpu_instr, m_instr);
      check("rsp_valid", rsp_valid, m_rv);
      if (m_rv) check("rsp_id", rsp_id, m_rid);
      check("rsp_data", rsp_data, m_rdata);
      check("busy", busy, m_locked || pend.size() != 0);
      check("owner", owner, m_owner);
    end
  end

  // ---------------- requester scripts ----------------
  typedef struct {logic [IW-1:0] instr; bit last; bit stall;} word_t;
  word_t q0[$], q1[$];
  int glog[$], ilog[$], rlog[$], dlog[$], exp[$];

  task automatic drive();
    req0_valid = q0.size() > 0 && !q0[0].stall;
    req0_instr = q0.size() > 0 ? q0[0].instr : '0;
    req0_last  = q0.size() > 0 ? q0[0].last : 1'b0;
    req1_valid = q1.size() > 0 && !q1[0].stall;
    req1_instr = q1.size() > 0 ? q1[0].instr : '0;
    req1_last  = q1.size() > 0 ? q1[0].last : 1'b0;
  endtask

  task automatic tick();
    bit a0, a1;
    @(negedge clk);
    a0 = req0_valid & req0_ready;
    a1 = req1_valid & req1_ready;
    if (a0) glog.push_back(0);
    if (a1) glog.push_back(1);
    if (tpu_instr != '0) ilog.push_back(int'(tpu_instr));
    if (rsp_valid) begin rlog.push_back(int'(rsp_id)); dlog.push_back(int'(rsp_data)); end
    @(posedge clk);
    #1;
    if (q0.size() > 0 && (a0 || q0[0].stall)) void'(q0.pop_front());
    if (q1.size() > 0 && (a1 || q1[0].stall)) void'(q1.pop_front());
    drive();
  endtask

  task automatic clear_logs();
    glog.delete(); ilog.delete(); rlog.delete(); dlog.delete();
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    drive();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check("script_drained", q0.size() + q1.size(), 0);
    repeat (RES_LAT + 3) tick();
  endtask

  task automatic check_seq(input string name, input int got[$], input int want[$]);
    check({name, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check(name, got[i], want[i]);
  endtask

  task automatic push(input int which, input logic [IW-1:0] ins, input bit last, input bit stall);
    if (which == 0) q0.push_back('{ins, last, stall});
    else q1.push_back('{ins, last, stall});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive();

    // Reset state
    do_reset();
    check("rst_tpu_instr", tpu_instr, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 1'b0);

    // 1: three-word burst from req0
    push(0, 16'hA001, 0, 0); push(0, 16'hA002, 0, 0); push(0, 16'hA003, 1, 0);
    drive();
    run(50);
    exp = '{0, 0, 0};                   check_seq("t1_grants", glog, exp);
    exp = '{'hA001, 'hA002, 'hA003};    check_seq("t1_issue", ilog, exp);
    exp = '{0, 0, 0};                   check_seq("t1_rsp_id", rlog, exp);
    exp = '{'hA1, 'hA2, 'hA3};          check_seq("t1_rsp_data", dlog, exp);

    // 2: both requesters stream single words, grants alternate
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      push(0, 16'h1000 + 16'(i), 1, 0);
      push(1, 16'h2000 + 16'(i), 1, 0);
    end
    drive();
    run(50);
    exp = '{0, 1, 0, 1, 0, 1};          check_seq("t2_grants", glog, exp);
    exp = '{0, 1, 0, 1, 0, 1};          check_seq("t2_rsp_id", rlog, exp);

    // 3: req1 burst of 10 without last, forced release after MAX_BURST
    do_reset();
    for (int i = 1; i <= 10; i++) push(1, 16'hB000 + 16'(i), 0, 0);
    drive();
    tick();
    push(0, 16'hC001, 1, 0);
    drive();
    run(60);
    exp = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    check_seq("t3_grants", glog, exp);

    // 4: owner stalls 3 cycles mid-burst
    do_reset();
    push(0, 16'hD001, 0, 0);
    push(0, 16'h0000, 0, 1); push(0, 16'h0000, 0, 1); push(0, 16'h0000, 0, 1);
    push(0, 16'hD002, 0, 0); push(0, 16'hD003, 1, 0);
    drive();
    tick();
    push(1, 16'hE001, 1, 0);
    drive();
    run(50);
    exp = '{0, 0, 0, 1};                         check_seq("t4_grants", glog, exp);
    exp = '{'hD001, 'hD002, 'hD003, 'hE001};     check_seq("t4_issue", ilog, exp);
    exp = '{0, 0, 0, 1};                         check_seq("t4_rsp_id", rlog, exp);

    // 5: reset one cycle after an accept, response in flight is discarded
    do_reset();
    push(0, 16'hF001, 1, 0);
    drive();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_tpu_instr", tpu_instr, 16'h0000);
    check("t5_busy", busy, 1'b0);
    check("t5_owner", owner, 1'b0);
    check("t5_rsp_valid", rsp_valid, 1'b0);
    rlog.delete();
    repeat (5) tick();
    check("t5_no_rsp", rlog.size(), 0);
    glog.delete();
    push(0, 16'h6001, 1, 0);
    push(1, 16'h7001, 1, 0);
    drive();
    run(20);
    exp = '{0, 1};                      check_seq("t5_ptr_grants", glog, exp);

    // 6: idle
    do_reset();
    repeat (5) begin
      tick();
      check("t6_tpu_instr", tpu_instr, 16'h0000);
      check("t6_busy", busy, 1'b0);
      check("t6_rsp_valid", rsp_valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_issue_arbiter.md
Name: tpu_issue_arbiter

Overview:
- Shares the single 16-bit `tpu` instruction port between two requesters, for example a host-pin loader and an on-chip test sequencer.
- Round-robin arbitration with burst locking, so a multi-instruction sequence is issued without interleaving.
- Drives the registered `tpu` instruction and issues NOP (16'h0000) when nothing is granted.
- Tags each issued instruction and routes the `tpu` 8-bit result back to the owning requester after a fixed latency.

Parameters:
- IW, 16, instruction width.
- RW, 8, result width.
- RES_LAT, 2, cycles from tpu_instr update to a valid tpu_result (>=1).
- MAX_BURST, 8, maximum transfers per lock before forced release (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_instr  in  IW  requester 0 instruction.
- req0_valid  in  1  requester 0 instruction valid.
- req0_last  in  1  final word of requester 0 burst.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req1_instr  in  IW  requester 1 instruction.
- req1_valid  in  1  requester 1 instruction valid.
- req1_last  in  1  final word of requester 1 burst.
- req1_ready  out  1  requester 1 transfer accepted this cycle.
- tpu_instr  out  IW  registered instruction to `tpu`.
- tpu_result  in  RW  result from `tpu`.
- rsp_data  out  RW  routed result.
- rsp_valid  out  1  rsp_data valid, one-cycle pulse.
- rsp_id  out  1  requester owning rsp_data.
- busy  out  1  lock held, or tag pipeline non-empty.
- owner  out  1  current or last lock owner.

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on rising clk.
  - rst is synchronous active-high.
  - Reset values: tpu_instr=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, owner=0, priority pointer=req0, burst count=0, tag pipeline cleared.
- States are IDLE and LOCKED(owner).
- Transfer: reqN_valid & reqN_ready in the same cycle.
- ready logic: combinational from state, pointer and valids; never depends on the ready signals themselves.
- IDLE:
  - Winner is the pointer-favoured requester if it is valid, else the other requester if it is valid.
  - Only the winner sees ready=1.
  - Winner's last=1: single-word burst; stay IDLE and point the pointer at the other requester.
  - Winner's last=0: go to LOCKED(winner) with burst count=1.
- LOCKED(o):
  - ready_o = req_o_valid; the other requester's ready = 0.
  - Owner valid low: issue NOP, hold the lock, burst count unchanged. There is no timeout, so requesters must not stall indefinitely mid-burst.
  - Transfer with last=1, or with burst count reaching MAX_BURST: go to IDLE, pointer = !o.
  - Forced release without last: the requester re-arbitrates; its remaining words form a new burst.
  - Otherwise burst count increments.
- Issue:
  - On a transfer, tpu_instr <= transferred instruction on the next edge.
  - With no transfer, tpu_instr <= 16'h0000 (NOP).
  - Issue latency: 1 cycle from accept to tpu_instr.
- Tag pipeline:
  - A (valid, id) pair enters alongside the tpu_instr register update.
  - It is delayed so that rsp_valid asserts RES_LAT cycles after tpu_instr shows the instruction.
  - rsp_data captures tpu_result in that cycle; data is registered, so both appear on the following edge.
  - Total accept-to-rsp_valid latency: 1+RES_LAT cycles.
  - NOP slots carry valid=0: rsp_valid stays low and rsp_data holds its value.
- One transfer per cycle maximum.
- Both requesters valid in IDLE: pointer decides.
- Back-to-back single-word requests from both requesters alternate 0,1,0,1.
- busy = (state==LOCKED) | any tag valid.
- owner updates on entry to LOCKED and on IDLE single-word grants.
- Reset mid-burst or with responses in flight: lock dropped, in-flight tags discarded, and no rsp_valid is produced for them.

Test Plan:
- Reset, then req0 sends 3 words A001,A002,A003(last) with RES_LAT=2 → tpu_instr shows A001..A003 on consecutive cycles 1 cycle after each accept; rsp_valid pulses 3 times with rsp_id=0, 3 cycles after each accept; req1_ready=0 throughout.
- req0 and req1 both valid with single words (last=1) every cycle for 6 cycles → grants alternate 0,1,0,1,0,1; rsp_id sequence matches.
- req1 burst of 10 words without last, MAX_BURST=8 → 8 words issued, forced release; req0 (valid, waiting) gets the next grant; req1's words 9-10 follow in a new burst.
- Owner drops valid for 3 cycles mid-burst → 3 NOP (0000) issued, no rsp_valid for those slots, other requester's ready stays 0, burst resumes.
- rst pulsed 1 cycle after an accept with results in flight → all outputs 0 next cycle, no rsp_valid ever produced for the flushed tag, pointer back to req0.
- No requests for 5 cycles → tpu_instr=0000, busy=0, rsp_valid=0.
